// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole round controller.
package mole_pkg;

  // Round controller states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_HIT,
    ST_MISS,
    ST_OVER
  } state_t;

  // Galois feedback mask for x^8 + x^6 + x^5 + x^4 + 1 (right-shifting form).
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  // Shortest timer reload the controller will ever program.
  localparam logic [2:0] INTERVAL_FLOOR = 3'd1;

endpackage

// File: rtl/mole_lfsr.sv
// 8-bit Galois LFSR used as the mole-position random source; advances every cycle.
module mole_lfsr
  import mole_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] value
);

  logic [7:0] lfsr_reg;

  // Shift right each cycle; when the bit shifted out is 1, fold in the feedback taps.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else if (lfsr_reg[0]) begin
      lfsr_reg <= (lfsr_reg >> 1) ^ LFSR_POLY;
    end else begin
      lfsr_reg <= lfsr_reg >> 1;
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: drives the countdown timer, lights one hole per
// round, judges button presses against it and keeps score and lives.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int         N_HOLES   = 4,
  parameter int         LIVES     = 3,
  parameter int         SCORE_W   = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [N_HOLES-1:0] btn,
  input  logic               timeout,
  output logic [2:0]         interval,
  output logic               dir,
  output logic               timer_rst_n,
  output logic [N_HOLES-1:0] mole,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic               round_active,
  output logic               game_over
);

  localparam int IDX_W = (N_HOLES > 1) ? $clog2(N_HOLES) : 1;

  state_t               state_reg;
  logic [N_HOLES-1:0]   btn_q;
  logic [N_HOLES-1:0]   mole_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic [SCORE_W-1:0]   score_reg;
  logic [2:0]           lives_reg;
  logic [2:0]           interval_reg;
  logic                 dir_reg;
  logic                 timer_rst_n_reg;
  logic                 round_active_reg;
  logic                 game_over_reg;

  logic [7:0]           lfsr_value;
  logic [IDX_W-1:0]     cand_idx;
  logic [IDX_W-1:0]     next_idx;
  logic [N_HOLES-1:0]   next_onehot;
  logic [N_HOLES-1:0]   rise;
  logic                 wrong_press;
  logic                 right_press;
  logic                 go_hit;
  logic                 go_miss;
  logic [2:0]           interval_calc;
  logic [SCORE_W-1:0]   score_sat;
  logic [2:0]           lives_dec;
  logic                 unused_lfsr_bits;

  mole_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_value)
  );

  // Only the low bits pick a hole; the rest of the LFSR state is intentionally unused.
  assign unused_lfsr_bits = ^lfsr_value[7:IDX_W];

  // Bump the candidate by one when it repeats the previous hole (wraps since N_HOLES is 2^k).
  assign cand_idx = lfsr_value[IDX_W-1:0];
  assign next_idx = (cand_idx == idx_reg) ? cand_idx + IDX_W'(1) : cand_idx;

  for (genvar gi = 0; gi < N_HOLES; gi++) begin : g_onehot
    assign next_onehot[gi] = (next_idx == IDX_W'(gi));
  end

  // A wrong rising edge dominates a correct one; a correct one dominates a timeout.
  assign rise        = btn & ~btn_q;
  assign wrong_press = |(rise & ~mole_reg);
  assign right_press = |(rise & mole_reg);
  assign go_hit      = ~wrong_press & right_press;
  assign go_miss     = wrong_press | (~right_press & timeout);

  // Timer reload shortens by one every four points and bottoms out once score reaches 24.
  assign interval_calc = (score_reg < SCORE_W'(24)) ? (3'd7 - score_reg[4:2]) : INTERVAL_FLOOR;

  assign score_sat = (&score_reg) ? score_reg : score_reg + SCORE_W'(1);
  assign lives_dec = (lives_reg == 3'd0) ? 3'd0 : lives_reg - 3'd1;

  // Round FSM with all outputs registered alongside the state transitions.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      btn_q            <= '0;
      mole_reg         <= '0;
      idx_reg          <= '0;
      score_reg        <= '0;
      lives_reg        <= 3'd0;
      interval_reg     <= 3'd7;
      dir_reg          <= 1'b0;
      timer_rst_n_reg  <= 1'b1;
      round_active_reg <= 1'b0;
      game_over_reg    <= 1'b0;
    end else begin
      btn_q <= btn;
      case (state_reg)
        ST_IDLE, ST_OVER: begin
          if (start) begin
            state_reg       <= ST_LOAD;
            score_reg       <= '0;
            lives_reg       <= 3'(LIVES);
            timer_rst_n_reg <= 1'b0;
            dir_reg         <= 1'b1;
            game_over_reg   <= 1'b0;
          end
        end
        ST_LOAD: begin
          state_reg        <= ST_RUN;
          idx_reg          <= next_idx;
          mole_reg         <= next_onehot;
          interval_reg     <= interval_calc;
          timer_rst_n_reg  <= 1'b1;
          round_active_reg <= 1'b1;
        end
        ST_RUN: begin
          if (go_miss) begin
            state_reg        <= ST_MISS;
            lives_reg        <= lives_dec;
            mole_reg         <= '0;
            round_active_reg <= 1'b0;
          end else if (go_hit) begin
            state_reg        <= ST_HIT;
            score_reg        <= score_sat;
            mole_reg         <= '0;
            round_active_reg <= 1'b0;
          end
        end
        ST_HIT: begin
          state_reg       <= ST_LOAD;
          timer_rst_n_reg <= 1'b0;
        end
        ST_MISS: begin
          if (lives_reg != 3'd0) begin
            state_reg       <= ST_LOAD;
            timer_rst_n_reg <= 1'b0;
          end else begin
            state_reg     <= ST_OVER;
            game_over_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign interval     = interval_reg;
  assign dir          = dir_reg;
  assign timer_rst_n  = timer_rst_n_reg;
  assign mole         = mole_reg;
  assign score        = score_reg;
  assign lives        = lives_reg;
  assign round_active = round_active_reg;
  assign game_over    = game_over_reg;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed scoreboard bench for mole_round_ctrl.
module tb_mole_round_ctrl;

  localparam int N     = 4;
  localparam int LIVES = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] btn;
  logic         timeout;
  logic [2:0]   interval;
  logic         dir;
  logic         timer_rst_n;
  logic [N-1:0] mole;
  logic [7:0]   score;
  logic [2:0]   lives;
  logic         round_active;
  logic         game_over;

  mole_round_ctrl #(
    .N_HOLES   (N),
    .LIVES     (LIVES),
    .SCORE_W   (8),
    .LFSR_SEED (8'hA5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .btn          (btn),
    .timeout      (timeout),
    .interval     (interval),
    .dir          (dir),
    .timer_rst_n  (timer_rst_n),
    .mole         (mole),
    .score        (score),
    .lives        (lives),
    .round_active (round_active),
    .game_over    (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t         sb[$];
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           score_m;
  int           lives_m;
  logic [N-1:0] last_mole;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb.size() == 0) begin
      tests_failed++;
      $error("FAIL sb_underflow observed=%0d expected=<queued value>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic int exp_interval(input int s);
    if (s < 24) return 7 - (s / 4);
    return 1;
  endfunction

  task automatic check_reset_vals(input string ctx);
    sb_push({ctx, "_interval"}, 7);
    sb_push({ctx, "_dir"}, 0);
    sb_push({ctx, "_timer_rst_n"}, 1);
    sb_push({ctx, "_mole"}, 0);
    sb_push({ctx, "_score"}, 0);
    sb_push({ctx, "_lives"}, 0);
    sb_push({ctx, "_round_active"}, 0);
    sb_push({ctx, "_game_over"}, 0);
    sb_check(32'(interval));
    sb_check(32'(dir));
    sb_check(32'(timer_rst_n));
    sb_check(32'(mole));
    sb_check(32'(score));
    sb_check(32'(lives));
    sb_check(32'(round_active));
    sb_check(32'(game_over));
    $display("[TB] %s: reset values checked", ctx);
  endtask

  // Checks made on the first RUN cycle of every round.
  task automatic check_round_entry(input string ctx);
    sb_push({ctx, "_onehot"}, 1);
    sb_push({ctx, "_new_hole"}, 1);
    sb_push({ctx, "_interval"}, 32'(exp_interval(score_m)));
    sb_push({ctx, "_timer_rst_n"}, 1);
    sb_push({ctx, "_round_active"}, 1);
    sb_push({ctx, "_dir"}, 1);
    sb_check(32'($onehot(mole)));
    sb_check(32'(mole != last_mole));
    sb_check(32'(interval));
    sb_check(32'(timer_rst_n));
    sb_check(32'(round_active));
    sb_check(32'(dir));
    $display("[TB] %s: run mole=%b prev=%b interval=%0d score=%0d lives=%0d",
             ctx, mole, last_mole, interval, score, lives);
    last_mole = mole;
  endtask

  // start pulse from IDLE/OVER: LOAD next cycle, RUN the cycle after.
  task automatic start_game(input string ctx);
    score_m = 0;
    lives_m = LIVES;
    sb_push({ctx, "_load_trst"}, 0);
    sb_push({ctx, "_load_lives"}, 32'(lives_m));
    sb_push({ctx, "_load_score"}, 0);
    sb_push({ctx, "_load_game_over"}, 0);
    sb_push({ctx, "_load_mole"}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    sb_check(32'(timer_rst_n));
    sb_check(32'(lives));
    sb_check(32'(score));
    sb_check(32'(game_over));
    sb_check(32'(mole));
    step();
    check_round_entry(ctx);
  endtask

  // Press the lit hole; optionally with timeout in the same cycle, optionally
  // pulse timeout during the following LOAD.
  task automatic hit(input string ctx, input bit with_to, input bit to_in_load);
    score_m = (score_m >= 255) ? 255 : score_m + 1;
    sb_push({ctx, "_score"}, 32'(score_m));
    sb_push({ctx, "_lives"}, 32'(lives_m));
    sb_push({ctx, "_mole_off"}, 0);
    sb_push({ctx, "_load_trst"}, 0);
    btn     = mole;
    timeout = with_to;
    step();
    timeout = 1'b0;
    sb_check(32'(score));
    sb_check(32'(lives));
    sb_check(32'(mole));
    btn = '0;
    step();
    sb_check(32'(timer_rst_n));
    timeout = to_in_load;
    step();
    timeout = 1'b0;
    check_round_entry(ctx);
    if (to_in_load) begin
      step();
      step();
      sb_push({ctx, "_load_to_active"}, 1);
      sb_push({ctx, "_load_to_lives"}, 32'(lives_m));
      sb_check(32'(round_active));
      sb_check(32'(lives));
      $display("[TB] %s: timeout during LOAD ignored, lives=%0d", ctx, lives);
    end
  endtask

  // Miss caused by a timeout pulse (wrong=0) or by correct+wrong rising together.
  task automatic miss(input string ctx, input bit both_buttons);
    lives_m = lives_m - 1;
    sb_push({ctx, "_lives"}, 32'(lives_m));
    sb_push({ctx, "_score"}, 32'(score_m));
    sb_push({ctx, "_active"}, 0);
    if (both_buttons) btn = mole | {mole[N-2:0], mole[N-1]};
    else timeout = 1'b1;
    step();
    timeout = 1'b0;
    btn     = '0;
    sb_check(32'(lives));
    sb_check(32'(score));
    sb_check(32'(round_active));
    $display("[TB] %s: miss lives=%0d score=%0d", ctx, lives, score);
    step();
    if (lives_m > 0) begin
      sb_push({ctx, "_load_trst"}, 0);
      sb_check(32'(timer_rst_n));
      step();
      check_round_entry(ctx);
    end else begin
      sb_push({ctx, "_game_over"}, 1);
      sb_push({ctx, "_over_score"}, 32'(score_m));
      sb_push({ctx, "_over_mole"}, 0);
      sb_push({ctx, "_over_trst"}, 1);
      sb_check(32'(game_over));
      sb_check(32'(score));
      sb_check(32'(mole));
      sb_check(32'(timer_rst_n));
      timeout = 1'b1;
      step();
      timeout = 1'b0;
      step();
      sb_push({ctx, "_over_hold_go"}, 1);
      sb_push({ctx, "_over_hold_lives"}, 0);
      sb_push({ctx, "_over_hold_score"}, 32'(score_m));
      sb_check(32'(game_over));
      sb_check(32'(lives));
      sb_check(32'(score));
      $display("[TB] %s: game over score=%0d", ctx, score);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    btn     = '0;
    timeout = 1'b0;
    score_m = 0;
    lives_m = 0;
    step();
    step();
    rst = 1'b0;
    last_mole = N'(1);   // previous index resets to 0
    check_reset_vals("reset");
    repeat (10) step();
    check_reset_vals("idle10");

    start_game("start1");
    hit("hit1", 1'b0, 1'b0);
    hit("hit2", 1'b0, 1'b0);
    hit("hit3", 1'b0, 1'b0);
    hit("hit4", 1'b0, 1'b0);     // entry check expects interval 6

    miss("to1", 1'b0);
    miss("to2", 1'b0);
    miss("to3", 1'b0);           // reaches OVER with score 4 held

    start_game("restart");
    miss("both", 1'b1);          // correct + wrong together
    hit("hit_to", 1'b1, 1'b1);   // correct + timeout -> HIT; timeout in LOAD ignored

    // Button held from IDLE through start must not register.
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_mole = N'(1);
    check_reset_vals("rst_idle");
    btn = '1;
    step();
    step();
    start_game("held");
    step();
    step();
    step();
    sb_push("held_active", 1);
    sb_push("held_score", 0);
    sb_push("held_lives", 3);
    sb_check(32'(round_active));
    sb_check(32'(score));
    sb_check(32'(lives));
    $display("[TB] held: active=%0d score=%0d lives=%0d", round_active, score, lives);

    // Reset in the middle of a round.
    rst = 1'b1;
    step();
    rst = 1'b0;
    btn = '0;
    check_reset_vals("rst_run");
    last_mole = N'(1);

    // Long run: distinct one-hot moles and interval floor with score above 24.
    start_game("soak_start");
    for (int r = 0; r < 200; r++) begin
      hit($sformatf("soak%0d", r), 1'b0, 1'b0);
    end
    sb_push("soak_final_interval", 1);
    sb_check(32'(interval));

    tests_run++;
    assert (sb.size() == 0) else begin
      tests_failed++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mole_round_ctrl.md
# mole_round_ctrl

Round controller for the whack-a-mole game: the initiator side of the timer interface. It programs the countdown timer (`interval`, `dir`, timer restart), consumes the timer's `timeout` pulse, picks the lit mole, and judges button hits against it. It also maintains score and lives. It sits between the debounced button inputs, the timer/seven-segment display block and the hole LEDs.

## Interface
- `N_HOLES`, 4: number of holes/buttons; must be a power of two, 2..8.
- `LIVES`, 3: lives granted at game start, 1..7.
- `SCORE_W`, 8: score width; score saturates at all-ones.
- `LFSR_SEED`, 8'hA5: non-zero LFSR reset value.

- `clk`  in  1  system clock.
- `rst`  in  1  reset: one clock; reset is synchronous and active-high.
- `start`  in  1  level; sampled only in IDLE and OVER.
- `btn`  in  N_HOLES  debounced button levels, 1 = pressed.
- `timeout`  in  1  one-cycle expiry pulse from the timer.
- `interval`  out  3  timer reload value.
- `dir`  out  1  timer direction; always 1 (count down) outside IDLE.
- `timer_rst_n`  out  1  active-low timer restart, pulsed for one cycle per round.
- `mole`  out  N_HOLES  one-hot lit hole; zero outside RUN.
- `score`  out  SCORE_W  hits this game.
- `lives`  out  3  remaining lives.
- `round_active`  out  1  high in RUN.
- `game_over`  out  1  high in OVER.

## Operation
- States: IDLE, LOAD, RUN, HIT, MISS, OVER.
- IDLE: `start`=1 → LOAD; `score` is cleared and `lives` is set to LIVES on the same edge.
- LOAD, one cycle:
  - `timer_rst_n`=0.
  - The new mole index is latched from the LFSR.
  - `interval` is updated.
  - Next state is RUN.
- RUN: `mole` = onehot(index). Per-cycle decision uses button rising edges, `rise = btn & ~btn_q`:
  - Any rise on a non-lit hole → MISS. A wrong press in the same cycle as a correct press still counts as a miss.
  - Otherwise, a rise on the lit hole → HIT.
  - Otherwise, `timeout`=1 → MISS.
  - A correct hit coinciding with `timeout` → HIT.
- HIT, one cycle: `score` +1, saturating. Next state is LOAD.
- MISS, one cycle: `lives` −1. Next state is LOAD if the new value is >0, else OVER.
- OVER: `game_over`=1 and `score`/`lives` hold. `start`=1 → LOAD with score and lives reinitialised, as from IDLE.
- `timeout` is ignored outside RUN. Buttons are ignored outside RUN, but `btn_q` tracks every cycle, so a button held into RUN does not count.
- `interval` = 7 − score[4:2] while score < 24, else 1. It is computed in LOAD from the updated score, giving range 1..7.
- LFSR: 8-bit Galois, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle including IDLE.
  - Candidate index = lfsr[log2(N_HOLES)−1:0].
  - If the candidate equals the previous index, use (candidate+1) mod N_HOLES, so consecutive rounds never repeat a hole.
- The previous index resets to 0.

## Timing
- Reset values:
  - state IDLE, `interval`=7, `dir`=0, `timer_rst_n`=1, `mole`=0, `score`=0, `lives`=0.
  - `round_active`=0, `game_over`=0, `btn_q`=0, LFSR=LFSR_SEED.
- All outputs are registered or decoded from registered state; there are no combinational input-to-output paths.
- `start` sampled at edge t → LOAD during t+1 (`timer_rst_n` low) → RUN from t+2 (`mole` valid).
- Button rise in RUN cycle t → HIT/MISS during t+1, with `score`/`lives` updated and visible from t+1 → LOAD t+2 → RUN t+3.
- `timeout` in RUN cycle t → MISS during t+1.
- `rst` asserted in any state returns to the reset values on the next edge. A round in progress is abandoned and the timer is not pulsed.
- `dir` goes to 1 on entry to LOAD and stays 1 until reset.

## Structure
- Package `mole_pkg`: the state enum (IDLE, LOAD, RUN, HIT, MISS, OVER), the LFSR polynomial constant, and the interval floor constant (1).
- Sub-module `mole_lfsr`:
  - 8-bit Galois LFSR with seed parameter.
  - Outputs the current value.
  - The controller instantiates it once.
- The FSM, edge detection, score, lives and interval logic stay in `mole_round_ctrl`.

## Test plan
- Reset then idle 10 cycles:
  - `mole`=0, `score`=0, `lives`=0, `timer_rst_n`=1.
  - `start`=1 for one cycle → `timer_rst_n`=0 exactly one cycle later, `mole` one-hot one cycle after that, `lives`=3, `interval`=7.
- Correct press in RUN → HIT the next cycle, `score`=1, new `mole` ≠ old `mole`. Four correct hits → `interval`=6 on the following LOAD.
- Three `timeout` pulses with no presses → `lives` 3→2→1→0, then `game_over`=1 with `score` held. `start` → `score`=0, `lives`=3.
- Correct and wrong button rising in the same RUN cycle → MISS. Correct press and `timeout` in the same cycle → HIT.
- Button held from IDLE through `start` → no HIT or MISS. `timeout` pulsed during LOAD → ignored.
- Assert `rst` during RUN → next cycle every output equals its reset value. Run 200 rounds → every `mole` is one-hot and never equal to the previous one, and `interval` never drops below 1 even with `score` > 24.
